// File: rtl/flappy_gfx_pkg.sv
// Shared graphics constants and types for the pipe sprite path.
package flappy_gfx_pkg;

  localparam int SCALE       = 2;
  localparam int PIPE_SIZE_X = 26 * SCALE;
  localparam int PIPE_SIZE_Y = 120 * SCALE;
  localparam int PIPE_GAP    = 50;
  localparam int NUM_PIPES   = 4;
  localparam int SCREEN_W    = 640;
  localparam int SCREEN_H    = 480;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SCAN   = 2'd1,
    S_COMMIT = 2'd2
  } sched_state_e;

  typedef struct packed {
    logic       hit;
    logic       top;
    logic [1:0] idx;
    logic       overlap;
  } hit_info_t;

  function automatic logic in_window(input logic signed [31:0] off, input int size);
    return (off >= 0) && (off < size);
  endfunction

endpackage

// File: rtl/pipe_hit_calc.sv
// Per-pipe X window test and sprite row/col for the current pixel.
module pipe_hit_calc
  import flappy_gfx_pkg::*;
(
  input  logic               display_on,
  input  logic signed [31:0] x,
  input  logic signed [31:0] y,
  input  logic signed [31:0] pipe_x,
  input  logic signed [31:0] pipe_y,
  input  logic               btm_en,
  input  logic               top_en,
  output logic               cand,
  output logic               is_top,
  output logic signed [31:0] row,
  output logic signed [31:0] col
);

  logic signed [31:0] x_off;
  logic signed [31:0] btm_off;
  logic signed [31:0] top_off;

  always_comb begin
    x_off   = x - pipe_x;
    btm_off = y - (pipe_y + PIPE_GAP);
    top_off = (pipe_y - PIPE_GAP) - y;
    cand    = display_on && (btm_en || top_en) && in_window(x_off, PIPE_SIZE_X);
    // Top half is the mirrored sprite; bottom wins if both are ever flagged.
    is_top  = top_en && !btm_en;
    row     = is_top ? (top_off / SCALE) : (btm_off / SCALE);
    col     = x_off / SCALE;
  end

endmodule

// File: rtl/pipe_sprite_scheduler.sv
// Shares the pipe sprite ROM between four pipes: per-line schedule in hblank,
// per-pixel fixed-priority arbitration, hit flags aligned to ROM data.
module pipe_sprite_scheduler
  import flappy_gfx_pkg::*;
#(
  parameter int ROM_LATENCY = 1
) (
  input  logic               VGA_clk,
  input  logic               rst,
  input  logic               frame_start,
  input  logic               line_start,
  input  logic signed [31:0] line_y,
  input  logic               display_on,
  input  logic signed [31:0] X,
  input  logic signed [31:0] Y,
  input  logic signed [31:0] pipeX_1,
  input  logic signed [31:0] pipeX_2,
  input  logic signed [31:0] pipeX_3,
  input  logic signed [31:0] pipeX_4,
  input  logic signed [31:0] pipeY_1,
  input  logic signed [31:0] pipeY_2,
  input  logic signed [31:0] pipeY_3,
  input  logic signed [31:0] pipeY_4,
  output logic [31:0]        rom_row,
  output logic [31:0]        rom_col,
  output logic               pipe_hit,
  output logic               pipe_top,
  output logic [1:0]         pipe_idx,
  output logic               overlap,
  output logic               sched_busy,
  output logic [1:0]         sched_state
);

  logic signed [31:0] pipe_x_in [NUM_PIPES];
  logic signed [31:0] pipe_y_in [NUM_PIPES];
  logic signed [31:0] px_q [NUM_PIPES];
  logic signed [31:0] px_d [NUM_PIPES];
  logic signed [31:0] py_q [NUM_PIPES];
  logic signed [31:0] py_d [NUM_PIPES];

  sched_state_e         state_q, state_d;
  logic [1:0]           k_q, k_d;
  logic signed [31:0]   line_y_q, line_y_d;
  logic [NUM_PIPES-1:0] pend_btm_q, pend_btm_d, pend_top_q, pend_top_d;
  logic [NUM_PIPES-1:0] act_btm_q, act_btm_d, act_top_q, act_top_d;
  logic signed [31:0]   scan_py, scan_btm_off, scan_top_off;

  logic [NUM_PIPES-1:0] cand, cand_top;
  logic signed [31:0]   row_k [NUM_PIPES];
  logic signed [31:0]   col_k [NUM_PIPES];
  logic [31:0]          rom_row_q, rom_row_d, rom_col_q, rom_col_d;
  hit_info_t            s1_info;
  hit_info_t            hit_pipe_q [ROM_LATENCY+1];
  hit_info_t            hit_pipe_d [ROM_LATENCY+1];

  assign pipe_x_in[0] = pipeX_1;
  assign pipe_x_in[1] = pipeX_2;
  assign pipe_x_in[2] = pipeX_3;
  assign pipe_x_in[3] = pipeX_4;
  assign pipe_y_in[0] = pipeY_1;
  assign pipe_y_in[1] = pipeY_2;
  assign pipe_y_in[2] = pipeY_3;
  assign pipe_y_in[3] = pipeY_4;

  // Shadows isolate the per-line and per-pixel logic from game-clock updates.
  always_comb begin
    px_d = px_q;
    py_d = py_q;
    if (frame_start) begin
      px_d = pipe_x_in;
      py_d = pipe_y_in;
    end
  end

  always_comb begin
    state_d      = state_q;
    k_d          = k_q;
    line_y_d     = line_y_q;
    pend_btm_d   = pend_btm_q;
    pend_top_d   = pend_top_q;
    act_btm_d    = act_btm_q;
    act_top_d    = act_top_q;
    scan_py      = py_q[k_q];
    scan_btm_off = line_y_q - (scan_py + PIPE_GAP);
    scan_top_off = (scan_py - PIPE_GAP) - line_y_q;
    if (line_start) begin
      // A new line request always restarts the scan; active masks keep serving pixels.
      state_d    = S_SCAN;
      k_d        = 2'd0;
      line_y_d   = line_y;
      pend_btm_d = '0;
      pend_top_d = '0;
    end else begin
      unique case (state_q)
        S_IDLE: ;
        S_SCAN: begin
          pend_btm_d[k_q] = in_window(scan_btm_off, PIPE_SIZE_Y);
          pend_top_d[k_q] = in_window(scan_top_off, PIPE_SIZE_Y);
          k_d             = k_q + 2'd1;
          if (k_q == 2'd3) state_d = S_COMMIT;
        end
        S_COMMIT: begin
          act_btm_d = pend_btm_q;
          act_top_d = pend_top_q;
          state_d   = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  for (genvar g = 0; g < NUM_PIPES; g++) begin : g_calc
    pipe_hit_calc u_calc (
      .display_on (display_on),
      .x          (X),
      .y          (Y),
      .pipe_x     (px_q[g]),
      .pipe_y     (py_q[g]),
      .btm_en     (act_btm_q[g]),
      .top_en     (act_top_q[g]),
      .cand       (cand[g]),
      .is_top     (cand_top[g]),
      .row        (row_k[g]),
      .col        (col_k[g])
    );
  end

  // Descending scan so the lowest-index candidate is written last and wins.
  always_comb begin
    rom_row_d = rom_row_q;
    rom_col_d = rom_col_q;
    s1_info   = '0;
    for (int i = NUM_PIPES - 1; i >= 0; i--) begin
      if (cand[i]) begin
        s1_info.hit = 1'b1;
        s1_info.top = cand_top[i];
        s1_info.idx = 2'(i);
        rom_row_d   = $unsigned(row_k[i]);
        rom_col_d   = $unsigned(col_k[i]);
      end
    end
    s1_info.overlap = ($countones(cand) > 1);
    hit_pipe_d[0]   = s1_info;
    for (int i = 1; i <= ROM_LATENCY; i++) hit_pipe_d[i] = hit_pipe_q[i-1];
  end

  always_ff @(posedge VGA_clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_PIPES; i++) begin
        px_q[i] <= '0;
        py_q[i] <= '0;
      end
      state_q    <= S_IDLE;
      k_q        <= '0;
      line_y_q   <= '0;
      pend_btm_q <= '0;
      pend_top_q <= '0;
      act_btm_q  <= '0;
      act_top_q  <= '0;
      rom_row_q  <= '0;
      rom_col_q  <= '0;
      for (int i = 0; i <= ROM_LATENCY; i++) hit_pipe_q[i] <= '0;
    end else begin
      px_q       <= px_d;
      py_q       <= py_d;
      state_q    <= state_d;
      k_q        <= k_d;
      line_y_q   <= line_y_d;
      pend_btm_q <= pend_btm_d;
      pend_top_q <= pend_top_d;
      act_btm_q  <= act_btm_d;
      act_top_q  <= act_top_d;
      rom_row_q  <= rom_row_d;
      rom_col_q  <= rom_col_d;
      hit_pipe_q <= hit_pipe_d;
    end
  end

  assign rom_row     = rom_row_q;
  assign rom_col     = rom_col_q;
  assign pipe_hit    = hit_pipe_q[ROM_LATENCY].hit;
  assign pipe_top    = hit_pipe_q[ROM_LATENCY].top;
  assign pipe_idx    = hit_pipe_q[ROM_LATENCY].idx;
  assign overlap     = hit_pipe_q[ROM_LATENCY].overlap;
  assign sched_busy  = (state_q == S_SCAN) || (state_q == S_COMMIT);
  assign sched_state = state_q;

endmodule

// File: tb/tb_pipe_sprite_scheduler.sv
// Directed bench for pipe_sprite_scheduler with hand-computed expectations.
module tb_pipe_sprite_scheduler;
  import flappy_gfx_pkg::*;

  logic               VGA_clk = 1'b0;
  logic               rst = 1'b1;
  logic               frame_start = 1'b0;
  logic               line_start = 1'b0;
  logic signed [31:0] line_y = '0;
  logic               display_on = 1'b0;
  logic signed [31:0] X = '0, Y = '0;
  logic signed [31:0] pipeX_1 = '0, pipeX_2 = '0, pipeX_3 = '0, pipeX_4 = '0;
  logic signed [31:0] pipeY_1 = '0, pipeY_2 = '0, pipeY_3 = '0, pipeY_4 = '0;
  logic [31:0]        rom_row, rom_col;
  logic               pipe_hit, pipe_top, overlap, sched_busy;
  logic [1:0]         pipe_idx, sched_state;

  int errors = 0;
  int checks = 0;
  int busy_cnt;

  pipe_sprite_scheduler #(.ROM_LATENCY(1)) dut (
    .VGA_clk (VGA_clk), .rst (rst), .frame_start (frame_start), .line_start (line_start),
    .line_y (line_y), .display_on (display_on), .X (X), .Y (Y),
    .pipeX_1 (pipeX_1), .pipeX_2 (pipeX_2), .pipeX_3 (pipeX_3), .pipeX_4 (pipeX_4),
    .pipeY_1 (pipeY_1), .pipeY_2 (pipeY_2), .pipeY_3 (pipeY_3), .pipeY_4 (pipeY_4),
    .rom_row (rom_row), .rom_col (rom_col), .pipe_hit (pipe_hit), .pipe_top (pipe_top),
    .pipe_idx (pipe_idx), .overlap (overlap), .sched_busy (sched_busy),
    .sched_state (sched_state)
  );

  // Clock / reset
  always #5 VGA_clk = ~VGA_clk;

  // Drivers: inputs change and outputs are sampled 1 time unit after the edge
  task automatic tick();
    @(posedge VGA_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  task automatic pulse_frame();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic run_schedule(input int ly);
    line_start = 1'b1;
    line_y     = ly;
    tick();
    line_start = 1'b0;
    repeat (5) tick();
  endtask

  // Hold a pixel for two cycles so both row/col and aligned flags reflect it
  task automatic pixel(input int px, input int py, input logic de);
    X = px;
    Y = py;
    display_on = de;
    tick();
    tick();
  endtask

  task automatic expect_hit(input string tag, input logic h, input logic t, input logic [1:0] idx,
                            input logic ov, input int row, input int col);
    check({tag, "_hit"}, pipe_hit, h);
    check({tag, "_top"}, pipe_top, t);
    check({tag, "_idx"}, pipe_idx, idx);
    check({tag, "_ovl"}, overlap, ov);
    check({tag, "_row"}, rom_row, row);
    check({tag, "_col"}, rom_col, col);
  endtask

  initial begin
    // Pipes 2..4 are parked far below the screen so they never match a line
    pipeX_1 = 100; pipeY_1 = 200;
    pipeX_2 = -500; pipeY_2 = 2000;
    pipeX_3 = 600; pipeY_3 = 2000;
    pipeX_4 = 0;   pipeY_4 = 2000;
    repeat (3) tick();
    expect_hit("reset", 0, 0, 2'd0, 0, 0, 0);
    check("reset_busy", sched_busy, 0);
    check("reset_state", sched_state, 0);
    rst = 1'b0;
    tick();

    // No line schedule yet: a sweep of the frame must never hit
    pulse_frame();
    display_on = 1'b1;
    for (int yy = 0; yy < SCREEN_H; yy += 16) begin
      for (int xx = 0; xx < SCREEN_W; xx += 8) begin
        X = xx;
        Y = yy;
        tick();
        check("sweep_hit", pipe_hit, 0);
        check("sweep_row", rom_row, 0);
        check("sweep_col", rom_col, 0);
      end
    end
    display_on = 1'b0;
    tick();
    tick();

    // Bottom pipe on line 260: busy for exactly 5 cycles
    line_start = 1'b1;
    line_y     = 260;
    tick();
    line_start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("busy_on", sched_busy, 1);
      tick();
    end
    check("busy_off", sched_busy, 0);
    X = 110; Y = 260; display_on = 1'b1;
    tick();
    check("btm_row_next", rom_row, 5);
    check("btm_col_next", rom_col, 5);
    check("btm_hit_early", pipe_hit, 0);
    tick();
    expect_hit("btm", 1, 0, 2'd0, 0, 5, 5);

    // Top (mirrored) pipe on line 140, right edge boundary
    run_schedule(140);
    pixel(151, 140, 1'b1);
    expect_hit("top_edge", 1, 1, 2'd0, 0, 5, 25);
    pixel(152, 140, 1'b1);
    expect_hit("past_edge", 0, 0, 2'd0, 0, 5, 25);

    // Pipes 1 and 3 coincide: lowest index wins and overlap is flagged
    pipeX_1 = 300; pipeX_3 = 300; pipeY_3 = 200;
    pulse_frame();
    run_schedule(300);
    pixel(310, 300, 1'b1);
    expect_hit("overlap", 1, 0, 2'd0, 1, 25, 5);
    pixel(310, 300, 1'b0);
    expect_hit("blank", 0, 0, 2'd0, 0, 25, 5);

    // Unlatched position change has no effect until frame_start
    pipeX_1 = 400;
    pixel(310, 300, 1'b1);
    expect_hit("no_latch", 1, 0, 2'd0, 1, 25, 5);
    pulse_frame();
    pixel(310, 300, 1'b1);
    expect_hit("latched_p3", 1, 0, 2'd2, 0, 25, 5);
    pixel(410, 300, 1'b1);
    expect_hit("latched_p1", 1, 0, 2'd0, 0, 25, 5);

    // Restart two cycles into SCAN: 7 busy cycles, old mask serves pixels meanwhile
    busy_cnt = 0;
    for (int c = 0; c < 12; c++) begin
      line_start = (c == 0) || (c == 2);
      line_y     = (c == 0) ? 100 : 140;
      tick();
      if (sched_busy) begin
        busy_cnt++;
        check("old_mask_hit", pipe_hit, 1);
        check("old_mask_top", pipe_top, 0);
      end
    end
    line_start = 1'b0;
    check("restart_busy_cycles", busy_cnt, 7);
    pixel(410, 140, 1'b1);
    expect_hit("restart_new", 1, 1, 2'd0, 0, 5, 5);

    // Reset mid-line clears masks and shadows
    rst = 1'b1;
    tick();
    expect_hit("midrst", 0, 0, 2'd0, 0, 0, 0);
    check("midrst_busy", sched_busy, 0);
    rst = 1'b0;
    pixel(410, 140, 1'b1);
    pixel(410, 140, 1'b1);
    expect_hit("post_rst", 0, 0, 2'd0, 0, 0, 0);

    // frame_start and line_start together: scan must see the new shadows
    pipeX_1 = 100; pipeY_1 = 400;
    display_on = 1'b0;
    frame_start = 1'b1;
    line_start  = 1'b1;
    line_y      = 300;
    tick();
    frame_start = 1'b0;
    line_start  = 1'b0;
    repeat (5) tick();
    pixel(110, 300, 1'b1);
    expect_hit("same_cycle", 1, 1, 2'd0, 0, 25, 5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
